// File: rtl/d_mem_arbiter_if.sv
// d_mem_arbiter_if: requester and memory signals of the data-memory arbiter.
// slave is the arbiter side, master is the requester/memory side.
interface d_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_err;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_err;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_err, m0_rvalid, m0_rdata,
        output m1_gnt, m1_err, m1_rvalid, m1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_err, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_err, m1_rvalid, m1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: two-port round-robin arbiter/sequencer for the data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins contention).
module d_mem_arbiter #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          MEM_DEPTH  = 1024
) (
    input logic            clk,
    input logic            reset,
    d_mem_arbiter_if.slave bus
);
    // One extra bit so the window end cannot wrap at the top of the space.
    localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] WIN_HI =
        WIN_LO + ((ADDR_WIDTH+1)'(MEM_DEPTH) << 2);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  win_q;
    logic                  we_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  any_req;
    logic                  win;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH:0]   sel_ext;
    logic                  sel_err;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                  last_q;
`endif

    // Pick the winner among current requests and classify its address.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = ~bus.m0_req;
`else
        if (bus.m0_req & bus.m1_req) begin
            win = ~last_q;
        end else begin
            win = bus.m1_req;
        end
`endif
        sel_we    = win ? bus.m1_we    : bus.m0_we;
        sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
        sel_ext   = {1'b0, sel_addr};
        sel_err   = (sel_ext < WIN_LO) | (sel_ext >= WIN_HI) |
                    (sel_addr[1:0] != 2'b00);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: read goes through RESP, write returns straight to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winning request when leaving IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            win_q   <= win;
            we_q    <= sel_we;
            err_q   <= sel_err;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Remember the last granted port for round-robin fairness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_q <= win;
        end
    end
`endif

    // Drive grants, memory strobes and read responses from the state.
    always_comb begin
        bus.m0_gnt    = 1'b0;
        bus.m0_err    = 1'b0;
        bus.m0_rvalid = 1'b0;
        bus.m0_rdata  = '0;
        bus.m1_gnt    = 1'b0;
        bus.m1_err    = 1'b0;
        bus.m1_rvalid = 1'b0;
        bus.m1_rdata  = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.busy      = (state_q != IDLE);
        if (state_q == ISSUE) begin
            bus.m0_gnt    = ~win_q;
            bus.m0_err    = ~win_q & err_q;
            bus.m1_gnt    = win_q;
            bus.m1_err    = win_q & err_q;
            bus.mem_read  = ~we_q & ~err_q;
            bus.mem_write = we_q & ~err_q;
        end
        if (state_q == RESP) begin
            bus.m0_rvalid = ~win_q;
            bus.m1_rvalid = win_q;
            if (!err_q) begin
                if (win_q) bus.m1_rdata = bus.mem_rdata;
                else       bus.m0_rdata = bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: directed scoreboard bench for d_mem_arbiter.
// Includes a 1-cycle registered-read memory model.
module tb_d_mem_arbiter;
    localparam logic [31:0] BASE = 32'h0001_0000;

    typedef struct {
        int          pid;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rv_cnt = 0;
    int   wr_cnt = 0;
    int   last_m = 1;
    exp_t exp_q[$];

    logic [31:0] mem [0:1023];
    logic [31:0] mem_q = '0;

    d_mem_arbiter_if bus ();

    d_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_read) mem_q <= mem[bus.mem_addr[11:2]];
        if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.m0_rvalid | bus.m1_rvalid) rv_cnt++;
        if (bus.mem_write) wr_cnt++;
        if (!reset)
            chk("onehot", {bus.m0_gnt & bus.m1_gnt,
                           bus.m0_rvalid & bus.m1_rvalid}, 0);
    end

    task automatic drive(input int p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.m0_req = r; bus.m0_we = we;
            bus.m0_addr = a; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = r; bus.m1_we = we;
            bus.m1_addr = a; bus.m1_wdata = wd;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(bus.m0_gnt | bus.m1_gnt) && n < 8);
        chk("gnt_seen", bus.m0_gnt | bus.m1_gnt, 1);
    endtask

    task automatic check_txn(input logic [31:0] a, input logic keep);
        exp_t e;
        e = exp_q.pop_front();
        chk("gnt0", bus.m0_gnt, e.pid == 0);
        chk("gnt1", bus.m1_gnt, e.pid == 1);
        chk("err", (e.pid == 1) ? bus.m1_err : bus.m0_err, e.err);
        chk("mem_read", bus.mem_read, !e.we && !e.err);
        chk("mem_write", bus.mem_write, e.we && !e.err);
        if (!e.err) chk("mem_addr", bus.mem_addr, a);
        if (!keep) begin
            if (e.pid == 0) bus.m0_req = 1'b0;
            else            bus.m1_req = 1'b0;
        end
        if (!e.we) begin
            @(posedge clk); #1;
            chk("rvalid0", bus.m0_rvalid, e.pid == 0);
            chk("rvalid1", bus.m1_rvalid, e.pid == 1);
            chk("rdata", (e.pid == 1) ? bus.m1_rdata : bus.m0_rdata,
                e.rdata);
            chk("rdata_other", (e.pid == 1) ? bus.m0_rdata : bus.m1_rdata,
                0);
        end
    endtask

    task automatic txn(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic eerr,
                       input logic [31:0] erd);
        int   n;
        logic idle0;
        exp_q.push_back('{pid: p, we: we, err: eerr, rdata: erd});
        idle0 = !bus.busy;
        drive(p, 1'b1, we, a, wd);
        wait_gnt(n);
        if (idle0) chk("gnt_lat", n, 1);
        check_txn(a, 1'b0);
    endtask

    task automatic contend(input int ngr);
        int n;
        int g;
        logic [31:0] a0 = BASE + 32'h10;
        logic [31:0] a1 = BASE + 32'h20;
        drive(0, 1'b1, 1'b0, a0, 0);
        drive(1, 1'b1, 1'b0, a1, 0);
        for (int k = 0; k < ngr; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = (last_m == 0) ? 1 : 0;
`endif
            last_m = g;
            exp_q.push_back('{pid: g, we: 1'b0, err: 1'b0,
                rdata: (g == 1) ? 32'hA500_0008 : 32'hA500_0004});
            wait_gnt(n);
            if (k == ngr - 1) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
            check_txn((g == 1) ? a1 : a0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int w0;
        int r0;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
        mem[2] = 32'hDEAD_BEEF;
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        reset = 1'b0;

        last_m = 1;
        contend(4);

        txn(0, 1'b0, 32'h0001_0008, 0, 1'b0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("busy_t3", bus.busy, 0);

        w0 = wr_cnt;
        c0 = cyc;
        txn(1, 1'b1, 32'h0001_0FFC, 32'h1234_5678, 1'b0, 0);
        txn(1, 1'b0, 32'h0001_0FFC, 0, 1'b0, 32'h1234_5678);
        n = 0;
        while (bus.busy && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_rd_span", cyc - c0, 5);
        chk("wr_once", wr_cnt - w0, 1);

        txn(0, 1'b0, 32'h0000_FFFC, 0, 1'b1, 0);
        txn(0, 1'b0, 32'h0001_1000, 0, 1'b1, 0);
        txn(0, 1'b0, 32'h0001_0002, 0, 1'b1, 0);
        w0 = wr_cnt;
        txn(1, 1'b1, 32'h0001_1000, 32'hCAFE_F00D, 1'b1, 0);
        @(posedge clk); #1;
        chk("err_no_write", wr_cnt - w0, 0);

        txn(0, 1'b0, 32'h0001_0000, 0, 1'b0, 32'hA500_0000);
        txn(1, 1'b0, 32'h0001_0FFC, 0, 1'b0, 32'h1234_5678);
        txn(0, 1'b0, 32'hFFFF_FFFC, 0, 1'b1, 0);
        @(posedge clk); #1;

        drive(0, 1'b1, 1'b0, 32'h0001_0008, 0);
        @(posedge clk); #1;
        bus.m0_req = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rvalid", bus.m0_rvalid, 1);
        reset = 1'b1;
        r0 = rv_cnt;
        #1;
        chk("arst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_rdata", bus.m0_rdata, 0);
        chk("arst_addr", bus.mem_addr, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_rvalid_after_rst", rv_cnt - r0, 0);
        last_m = 1;
        contend(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/d_mem_arbiter.md
Name: d_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (registered read, 1-cycle latency, word-addressed from BASE_ADDR).
- Port 0 is the CPU load/store unit; port 1 is a secondary master (DMA or debug).
- Arbitrates with round-robin, checks address range and alignment, drives the memory's read/write strobes, and returns read data with a valid pulse.
- Exactly one memory transaction is in flight at any time.

Parameters:
- ADDR_WIDTH, 32, address width of requesters and memory.
- DATA_WIDTH, 32, data width.
- BASE_ADDR, 32'h0001_0000, first byte address of the memory window.
- MEM_DEPTH, 1024, memory depth in words. Window is BASE_ADDR to BASE_ADDR+(MEM_DEPTH<<2)-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  port 0 request; held with fields stable until m0_gnt.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  ADDR_WIDTH  byte address.
- m0_wdata  input  DATA_WIDTH  write data.
- m0_gnt  output  1  one-cycle grant pulse.
- m0_err  output  1  qualified by m0_gnt; address out of window or misaligned.
- m0_rvalid  output  1  one-cycle read-data-valid pulse.
- m0_rdata  output  DATA_WIDTH  read data, valid while m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_err, m1_rvalid, m1_rdata  same as port 0, for port 1.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  registered memory read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE, ISSUE, RESP. Transitions:
  - IDLE to ISSUE when any request is present.
  - ISSUE to RESP for a read.
  - ISSUE to IDLE for a write.
  - RESP to IDLE unconditionally.
- IDLE, on the edge with any mN_req high:
  - Selects the winner and latches winner id, we, addr, wdata into internal registers.
  - Latches err_q = (addr < BASE_ADDR) | (addr >= BASE_ADDR+(MEM_DEPTH<<2)) | (addr[1:0] != 0). Compute with ADDR_WIDTH+1-bit arithmetic so the window end cannot wrap.
- Round-robin:
  - last_gnt register, reset value 1, so port 0 wins the first contention.
  - If both ports request, the port not equal to last_gnt wins. If one port requests, it wins.
  - last_gnt updates on every grant.
- ISSUE (exactly 1 cycle):
  - Winner's gnt = 1 and err = err_q.
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_read = ~we & ~err_q; mem_write = we & ~err_q.
  - Requester may change or drop its req from the next cycle on.
- RESP (reads only, 1 cycle):
  - Winner's rvalid = 1.
  - rdata = err_q ? 0 : mem_rdata, passed through combinationally from the memory's registered output.
- Latency from req sampled in IDLE:
  - Grant is 1 cycle later; read data is 2 cycles later.
  - A read occupies 3 cycles (IDLE, ISSUE, RESP); a write occupies 2 cycles.
- Outside the active states:
  - mem_read, mem_write, all gnt/err/rvalid are 0.
  - mem_addr, mem_wdata hold the latched values.
  - Non-winner rdata is 0.
- Requests arriving in ISSUE or RESP are ignored until the next IDLE. Requesters hold req, so nothing is lost.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; last_gnt = 1.
  - All outputs 0; latched registers 0.
  - An aborted write may or may not have reached memory; an aborted read returns no rvalid.
- Only one of m0_gnt/m1_gnt and only one of m0_rvalid/m1_rvalid is ever high in a given cycle.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins contention. last_gnt is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Single read: m0 reads 0x0001_0008 with mem word 2 = 0xDEAD_BEEF -> m0_gnt at T+1 with mem_read=1, mem_addr=0x0001_0008; m0_rvalid=1, m0_rdata=0xDEAD_BEEF at T+2; busy low at T+3.
- Write then read-back on port 1:
  - Stimulus: write 0x1234_5678 to 0x0001_0FFC, then read the same address.
  - Required: mem_write=1 for exactly 1 cycle; the read returns 0x1234_5678.
  - Required: back-to-back write+read spans 5 cycles.
- Contention after reset: both ports request continuously, all reads -> grant order m0, m1, m0, m1. With DMEM_ARB_FIXED_PRIO_EN defined, the order is m0, m0, m0.
- Range and alignment errors:
  - Stimulus: m0 reads 0x0000_FFFC, then 0x0001_1000, then 0x0001_0002.
  - Required: each gets m0_gnt with m0_err=1 and mem_read=0; m0_rvalid pulses with m0_rdata=0.
  - Stimulus: m1 writes 0x0001_1000.
  - Required: m1_err=1 and no mem_write.
- Reset mid-read: assert reset during RESP -> all outputs 0 immediately (asynchronous); no rvalid after release. The next contention grants m0 first.
- Boundary address: read 0x0001_0000 and 0x0001_0FFC -> both have err=0 and memory is accessed. For 0xFFFF_FFFC, err=1 with no wrap-around false hit.
